// File: rtl/marble_pkg.sv
// Shared types for the marble dispenser: FSM states and marble colours.
package marble_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RELEASE,
      FLIGHT,
      HALTED
   } state_t;

   typedef enum logic {
      BLUE,
      RED
   } colour_t;

endpackage

// File: rtl/async_edge_sync.sv
// Two-flop synchronizer for an asynchronous board signal, followed by a registered
// rising-edge detector. The synchronized level and the 1-cycle rise event are both exposed.
module async_edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic level,
   output logic rise
);

   logic meta;
   logic sync;
   logic sync_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta   <= 1'b0;
         sync   <= 1'b0;
         sync_d <= 1'b0;
         rise   <= 1'b0;
      end else begin
         meta   <= async_in;
         sync   <= meta;
         sync_d <= sync;
         rise   <= sync & ~sync_d;
      end
   end

   assign level = sync;

endmodule

// File: rtl/marble_dispenser.sv
// Marble source: holds blue/red magazines and releases one marble per trigger as a
// PULSE_CYCLES-wide pulse into the left (blue) or right (red) drop column.
module marble_dispenser
   import marble_pkg::*;
#(
   parameter int BLUE_INIT    = 8,
   parameter int RED_INIT     = 8,
   parameter int CNT_W        = 4,
   parameter int PULSE_CYCLES = 4,
   parameter int TIMEOUT      = 1024,
   parameter int TO_W         = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic             i_lever_left,
   input  logic             i_lever_right,
   input  logic             i_halt,
   input  logic             i_reload,
   output logic             o_left,
   output logic             o_right,
   output logic [CNT_W-1:0] blue_count,
   output logic [CNT_W-1:0] red_count,
   output logic             busy,
   output logic             halted
);

   localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
   localparam logic [PW-1:0]    PULSE_LAST = PW'(PULSE_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] BLUE_FULL  = CNT_W'(BLUE_INIT);
   localparam logic [CNT_W-1:0] RED_FULL   = CNT_W'(RED_INIT);

   logic start_evt, left_evt, right_evt, halt_lvl;
   logic unused_start_lvl, unused_left_lvl, unused_right_lvl, unused_halt_rise;

   async_edge_sync u_start (.clk(clk), .rst(rst), .async_in(i_start),
                            .level(unused_start_lvl), .rise(start_evt));
   async_edge_sync u_left  (.clk(clk), .rst(rst), .async_in(i_lever_left),
                            .level(unused_left_lvl), .rise(left_evt));
   async_edge_sync u_right (.clk(clk), .rst(rst), .async_in(i_lever_right),
                            .level(unused_right_lvl), .rise(right_evt));
   async_edge_sync u_halt  (.clk(clk), .rst(rst), .async_in(i_halt),
                            .level(halt_lvl), .rise(unused_halt_rise));

   state_t           state, state_n;
   colour_t          colour, colour_n;
   logic [PW-1:0]    pcnt, pcnt_n;
   logic [TO_W-1:0]  tcnt, tcnt_n;
   logic [CNT_W-1:0] blue_n, red_n;
   logic             left_n, right_n;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         colour     <= BLUE;
         pcnt       <= '0;
         tcnt       <= '0;
         blue_count <= BLUE_FULL;
         red_count  <= RED_FULL;
         o_left     <= 1'b0;
         o_right    <= 1'b0;
      end else begin
         state      <= state_n;
         colour     <= colour_n;
         pcnt       <= pcnt_n;
         tcnt       <= tcnt_n;
         blue_count <= blue_n;
         red_count  <= red_n;
         o_left     <= left_n;
         o_right    <= right_n;
      end
   end

   always_comb begin
      state_n  = state;
      colour_n = colour;
      pcnt_n   = pcnt;
      tcnt_n   = tcnt;
      blue_n   = blue_count;
      red_n    = red_count;
      // Halt overrides everything, including a reload or an in-progress pulse.
      if (halt_lvl) begin
         state_n = HALTED;
      end else begin
         case (state)
            IDLE: begin
               if (i_reload) begin
                  blue_n = BLUE_FULL;
                  red_n  = RED_FULL;
               end else if (start_evt) begin
                  if (blue_count != '0) begin
                     blue_n   = blue_count - CNT_W'(1);
                     colour_n = BLUE;
                     pcnt_n   = '0;
                     state_n  = RELEASE;
                  end else begin
                     state_n = HALTED;
                  end
               end
            end
            RELEASE: begin
               if (pcnt == PULSE_LAST) begin
                  state_n = FLIGHT;
                  tcnt_n  = '0;
               end else begin
                  pcnt_n = pcnt + PW'(1);
               end
            end
            FLIGHT: begin
               // Left lever has priority; a simultaneous right hit is discarded.
               if (left_evt) begin
                  if (blue_count != '0) begin
                     blue_n   = blue_count - CNT_W'(1);
                     colour_n = BLUE;
                     pcnt_n   = '0;
                     state_n  = RELEASE;
                  end else begin
                     state_n = HALTED;
                  end
               end else if (right_evt) begin
                  if (red_count != '0) begin
                     red_n    = red_count - CNT_W'(1);
                     colour_n = RED;
                     pcnt_n   = '0;
                     state_n  = RELEASE;
                  end else begin
                     state_n = HALTED;
                  end
               end else if ((TIMEOUT != 0) && (tcnt == TO_LAST)) begin
                  state_n = IDLE;
               end else begin
                  tcnt_n = tcnt + TO_W'(1);
               end
            end
            HALTED: begin
               if (i_reload) begin
                  blue_n  = BLUE_FULL;
                  red_n   = RED_FULL;
                  state_n = IDLE;
               end
            end
            default: state_n = IDLE;
         endcase
      end
      left_n  = (state_n == RELEASE) && (colour_n == BLUE);
      right_n = (state_n == RELEASE) && (colour_n == RED);
   end

   assign busy   = (state == RELEASE) || (state == FLIGHT);
   assign halted = (state == HALTED);

endmodule

// File: tb/tb_marble_dispenser.sv
// Directed bench for marble_dispenser: a per-cycle vector table for the main release
// flow plus hand-written sequences for halt, reset, empty magazine and timeout.
module tb_marble_dispenser;

   logic clk;
   logic rst;
   logic start, lever_left, lever_right, halt, reload;

   logic       o_left0, o_right0, busy0, halted0;
   logic [3:0] blue0, red0;
   logic       o_left1, o_right1, busy1, halted1;
   logic [3:0] blue1, red1;

   int n_tests = 0;
   int n_fail  = 0;

   marble_dispenser dut0 (
      .clk(clk), .rst(rst), .i_start(start), .i_lever_left(lever_left),
      .i_lever_right(lever_right), .i_halt(halt), .i_reload(reload),
      .o_left(o_left0), .o_right(o_right0), .blue_count(blue0), .red_count(red0),
      .busy(busy0), .halted(halted0)
   );

   marble_dispenser #(.BLUE_INIT(1), .TIMEOUT(16)) dut1 (
      .clk(clk), .rst(rst), .i_start(start), .i_lever_left(lever_left),
      .i_lever_right(lever_right), .i_halt(halt), .i_reload(reload),
      .o_left(o_left1), .o_right(o_right1), .blue_count(blue1), .red_count(red1),
      .busy(busy1), .halted(halted1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Input encodings: {start, left, right, halt, reload}
   localparam logic [4:0] NONE = 5'b00000;
   localparam logic [4:0] ST   = 5'b10000;
   localparam logic [4:0] LF   = 5'b01000;
   localparam logic [4:0] RT   = 5'b00100;
   localparam logic [4:0] LR   = 5'b01100;
   localparam logic [4:0] HT   = 5'b00010;
   localparam logic [4:0] RL   = 5'b00001;

   typedef struct {
      logic [4:0] in;
      logic       e_left;
      logic       e_right;
      logic [3:0] e_blue;
      logic [3:0] e_red;
      logic       e_busy;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [11:0] pk(input logic l, input logic r, input logic [3:0] b,
                                      input logic [3:0] rd, input logic bu, input logic h);
      return {l, r, b, rd, bu, h};
   endfunction

   function automatic logic [11:0] st0();
      return {o_left0, o_right0, blue0, red0, busy0, halted0};
   endfunction

   function automatic logic [11:0] st1();
      return {o_left1, o_right1, blue1, red1, busy1, halted1};
   endfunction

   task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got {l,r,blue,red,busy,halted}=%b required %b", name, act, exp);
      end
   endtask

   task automatic span(input int n, input logic [4:0] in, input logic [1:0] o,
                       input logic [3:0] b, input logic [3:0] r, input logic bu);
      vec_t v;
      v.in = in; v.e_left = o[1]; v.e_right = o[0];
      v.e_blue = b; v.e_red = r; v.e_busy = bu;
      for (int k = 0; k < n; k++) tbl.push_back(v);
   endtask

   task automatic tick(input logic [4:0] in);
      @(negedge clk);
      {start, lever_left, lever_right, halt, reload} = in;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      {start, lever_left, lever_right, halt, reload} = NONE;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      {start, lever_left, lever_right, halt, reload} = NONE;

      // Row k is sampled at edge k after reset; outputs checked just after that edge.
      span(2, ST,   2'b00, 4'd8, 4'd8, 1'b0);
      span(1, NONE, 2'b00, 4'd8, 4'd8, 1'b0);
      span(4, NONE, 2'b10, 4'd7, 4'd8, 1'b1);
      span(1, NONE, 2'b00, 4'd7, 4'd8, 1'b1);
      span(2, RT,   2'b00, 4'd7, 4'd8, 1'b1);
      span(1, NONE, 2'b00, 4'd7, 4'd8, 1'b1);
      span(4, NONE, 2'b01, 4'd7, 4'd7, 1'b1);
      span(1, NONE, 2'b00, 4'd7, 4'd7, 1'b1);
      span(2, LR,   2'b00, 4'd7, 4'd7, 1'b1);
      span(1, NONE, 2'b00, 4'd7, 4'd7, 1'b1);
      span(4, NONE, 2'b10, 4'd6, 4'd7, 1'b1);
      span(1, NONE, 2'b00, 4'd6, 4'd7, 1'b1);
      span(2, LF,   2'b00, 4'd6, 4'd7, 1'b1);
      span(1, NONE, 2'b00, 4'd6, 4'd7, 1'b1);
      span(1, NONE, 2'b10, 4'd5, 4'd7, 1'b1);
      span(2, RT,   2'b10, 4'd5, 4'd7, 1'b1);
      span(1, NONE, 2'b10, 4'd5, 4'd7, 1'b1);
      span(4, NONE, 2'b00, 4'd5, 4'd7, 1'b1);

      do_reset();
      #1;
      chk("reset_dut0", st0(), pk(1'b0, 1'b0, 4'd8, 4'd8, 1'b0, 1'b0));
      chk("reset_dut1", st1(), pk(1'b0, 1'b0, 4'd1, 4'd8, 1'b0, 1'b0));

      foreach (tbl[i]) begin
         tick(tbl[i].in);
         chk($sformatf("row%0d", i), st0(),
             pk(tbl[i].e_left, tbl[i].e_right, tbl[i].e_blue, tbl[i].e_red, tbl[i].e_busy, 1'b0));
      end

      // Halt mid-pulse truncates the pulse; reload is ignored while halt is held.
      do_reset();
      tick(ST); tick(ST); tick(NONE);
      tick(HT);
      chk("halt_pulse_on", st0(), pk(1'b1, 1'b0, 4'd7, 4'd8, 1'b1, 1'b0));
      tick(HT);
      chk("halt_pulse_still", st0(), pk(1'b1, 1'b0, 4'd7, 4'd8, 1'b1, 1'b0));
      tick(HT);
      chk("halt_truncated", st0(), pk(1'b0, 1'b0, 4'd7, 4'd8, 1'b0, 1'b1));
      tick(HT | RL);
      chk("reload_while_halt", st0(), pk(1'b0, 1'b0, 4'd7, 4'd8, 1'b0, 1'b1));
      tick(HT); tick(NONE); tick(NONE); tick(NONE);
      chk("halted_hold", st0(), pk(1'b0, 1'b0, 4'd7, 4'd8, 1'b0, 1'b1));
      tick(RL);
      chk("reload_ok", st0(), pk(1'b0, 1'b0, 4'd8, 4'd8, 1'b0, 1'b0));

      // Asynchronous reset mid-pulse drops the output without a clock edge.
      do_reset();
      tick(ST); tick(ST); tick(NONE); tick(NONE);
      chk("pre_rst_pulse", st0(), pk(1'b1, 1'b0, 4'd7, 4'd8, 1'b1, 1'b0));
      #2;
      rst = 1'b1;
      #1;
      chk("rst_async", st0(), pk(1'b0, 1'b0, 4'd8, 4'd8, 1'b0, 1'b0));
      @(negedge clk);
      rst = 1'b0;

      // Empty blue magazine: a left hit in FLIGHT halts without a pulse.
      do_reset();
      tick(ST); tick(ST); tick(NONE); tick(NONE);
      chk("d1_release", st1(), pk(1'b1, 1'b0, 4'd0, 4'd8, 1'b1, 1'b0));
      tick(NONE); tick(NONE); tick(NONE); tick(NONE);
      chk("d1_flight", st1(), pk(1'b0, 1'b0, 4'd0, 4'd8, 1'b1, 1'b0));
      tick(LF); tick(LF); tick(NONE);
      chk("d1_no_pulse", st1(), pk(1'b0, 1'b0, 4'd0, 4'd8, 1'b1, 1'b0));
      tick(NONE);
      chk("d1_empty_halt", st1(), pk(1'b0, 1'b0, 4'd0, 4'd8, 1'b0, 1'b1));
      tick(RL);
      chk("d1_reload", st1(), pk(1'b0, 1'b0, 4'd1, 4'd8, 1'b0, 1'b0));

      // Flight timeout after 16 cycles; a later lever hit is ignored in IDLE.
      do_reset();
      tick(ST); tick(ST); tick(NONE);
      for (int i = 3; i <= 22; i++) tick(NONE);
      chk("d1_flight_last", st1(), pk(1'b0, 1'b0, 4'd0, 4'd8, 1'b1, 1'b0));
      tick(NONE);
      chk("d1_timeout", st1(), pk(1'b0, 1'b0, 4'd0, 4'd8, 1'b0, 1'b0));
      tick(LF); tick(LF);
      for (int i = 0; i < 4; i++) begin
         tick(NONE);
         chk($sformatf("d1_lever_ignored%0d", i), st1(), pk(1'b0, 1'b0, 4'd0, 4'd8, 1'b0, 1'b0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
